// File: rtl/vector_loader.sv
// vector_loader: assembles (x,w) element pairs into N-lane vectors, zero-padding short ones; out_valid 1 clk after completion.
// Backpressure: in_ready drops while no bank is filling. Define VECTOR_LOADER_DOUBLE_BUFFER_EN for two ping-pong banks.
`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif

module vector_loader #(
  parameter int N          = 4,
  parameter int DATA_WIDTH = `DATA_WIDTH
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic signed [DATA_WIDTH-1:0] in_x,
  input  logic signed [DATA_WIDTH-1:0] in_w,
  input  logic                         in_last,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic signed [DATA_WIDTH-1:0] out_x [N],
  output logic signed [DATA_WIDTH-1:0] out_w [N],
  output logic [$clog2(N+1)-1:0]       out_len
);

  localparam int IW = $clog2(N);
  localparam int LW = $clog2(N+1);
`ifdef VECTOR_LOADER_DOUBLE_BUFFER_EN
  localparam int NB = 2;
`else
  localparam int NB = 1;
`endif

  typedef enum logic {FILL = 1'b0, FULL = 1'b1} bank_st_t;

  bank_st_t                     st_q  [NB];
  logic signed [DATA_WIDTH-1:0] x_q   [NB][N];
  logic signed [DATA_WIDTH-1:0] w_q   [NB][N];
  logic [LW-1:0]                len_q [NB];
  logic [IW-1:0]                idx;
  logic                         fill_ptr;
  logic                         drain_ptr;
  logic                         in_beat;
  logic                         out_beat;
  logic                         done;

  assign in_ready  = (st_q[fill_ptr] == FILL);
  assign out_valid = (st_q[drain_ptr] == FULL);
  assign in_beat   = in_valid && in_ready;
  assign out_beat  = out_valid && out_ready;
  assign done      = in_beat && (in_last || (idx == IW'(N-1)));

  always_comb begin
    for (int l = 0; l < N; l++) begin
      out_x[l] = x_q[drain_ptr][l];
      out_w[l] = w_q[drain_ptr][l];
    end
  end
  assign out_len = len_q[drain_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx <= '0;
      for (int b = 0; b < NB; b++) begin
        st_q[b]  <= FILL;
        len_q[b] <= '0;
        for (int l = 0; l < N; l++) begin
          x_q[b][l] <= '0;
          w_q[b][l] <= '0;
        end
      end
    end else begin
      // Drain and fill target different banks whenever both fire together.
      if (out_beat) st_q[drain_ptr] <= FILL;
      if (in_beat) begin
        x_q[fill_ptr][idx] <= in_x;
        w_q[fill_ptr][idx] <= in_w;
        if (done) begin
          // Clear lanes above the last written one so a reused bank never shows stale data.
          for (int l = 0; l < N; l++) begin
            if (IW'(l) > idx) begin
              x_q[fill_ptr][l] <= '0;
              w_q[fill_ptr][l] <= '0;
            end
          end
          len_q[fill_ptr] <= LW'(idx) + LW'(1);
          st_q[fill_ptr]  <= FULL;
          idx             <= '0;
        end else begin
          idx <= idx + IW'(1);
        end
      end
    end
  end

`ifdef VECTOR_LOADER_DOUBLE_BUFFER_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fill_ptr  <= 1'b0;
      drain_ptr <= 1'b0;
    end else begin
      if (done)     fill_ptr  <= ~fill_ptr;
      if (out_beat) drain_ptr <= ~drain_ptr;
    end
  end
`else
  assign fill_ptr  = 1'b0;
  assign drain_ptr = 1'b0;
`endif

endmodule

// File: tb/tb_vector_loader.sv
// Directed bench for vector_loader (N=4, 8-bit): table of vectors plus reset, backpressure, streaming and coincidence sequences.
module tb_vector_loader;
  localparam int N  = 4;
  localparam int DW = 8;
`ifdef VECTOR_LOADER_DOUBLE_BUFFER_EN
  localparam int SPV    = 4;  // cycles per vector when streaming
  localparam int BP_ACC = 8;  // beats accepted while out_ready is low
`else
  localparam int SPV    = 5;
  localparam int BP_ACC = 4;
`endif

  typedef logic signed [DW-1:0] elem_t;
  typedef logic [N-1:0][DW-1:0] lanes_t;
  typedef struct packed { lanes_t x; lanes_t w; logic [2:0] len; } vec_t;
  typedef struct packed { logic [3:0] n; logic last; lanes_t ix; lanes_t iw; vec_t e; } tv_t;

  logic  clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, in_last = 1'b0, out_ready = 1'b1;
  elem_t in_x = '0, in_w = '0;
  logic  in_ready, out_valid;
  elem_t out_x [N];
  elem_t out_w [N];
  logic [2:0] out_len;

  int   checks = 0, errors = 0, cyc = 0;
  vec_t exp_q [$];
  int   in_log [$];
  int   out_log [$];
  vec_t m = '0;
  int   m_idx = 0;
  tv_t  tv [6];

  vector_loader #(.N(N), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_x(in_x), .in_w(in_w), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_x(out_x), .out_w(out_w), .out_len(out_len)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic lanes_t mk(input int a0, input int a1, input int a2, input int a3);
    lanes_t r;
    r[0] = a0[DW-1:0]; r[1] = a1[DW-1:0]; r[2] = a2[DW-1:0]; r[3] = a3[DW-1:0];
    return r;
  endfunction

  function automatic vec_t dut_vec();
    vec_t v;
    for (int l = 0; l < N; l++) begin
      v.x[l] = out_x[l];
      v.w[l] = out_w[l];
    end
    v.len = out_len;
    return v;
  endfunction

  function automatic int dot(input vec_t v);
    int s = 0;
    for (int l = 0; l < N; l++) s += int'($signed(v.x[l])) * int'($signed(v.w[l]));
    return s;
  endfunction

  task automatic set_tv(input int i, input int n, input bit last, input lanes_t ix, input lanes_t iw,
                        input lanes_t ex, input lanes_t ew, input int len);
    tv[i].n = n[3:0]; tv[i].last = last; tv[i].ix = ix; tv[i].iw = iw;
    tv[i].e.x = ex; tv[i].e.w = ew; tv[i].e.len = len[2:0];
  endtask

  // Reference: an element lands in the next lane; completion pads and queues the expected vector.
  task automatic model_beat(input elem_t x, input elem_t w, input bit last);
    m.x[m_idx] = x;
    m.w[m_idx] = w;
    if (last || m_idx == N-1) begin
      for (int l = m_idx + 1; l < N; l++) begin
        m.x[l] = '0;
        m.w[l] = '0;
      end
      m.len = 3'(m_idx + 1);
      exp_q.push_back(m);
      m_idx = 0;
    end else begin
      m_idx++;
    end
  endtask

  // Called at a negedge; drives one cycle and returns at the next negedge.
  task automatic step(input bit v, input elem_t x, input elem_t w, input bit last, output bit took);
    in_valid = v; in_x = x; in_w = w; in_last = last;
    took = v && in_ready && rst_n;
    if (took) model_beat(x, w, last);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    bit t;
    for (int i = 0; i < n; i++) step(1'b0, '0, '0, 1'b0, t);
  endtask

  task automatic send(input elem_t x, input elem_t w, input bit last);
    bit took = 1'b0;
    for (int i = 0; i < 40 && !took; i++) step(1'b1, x, w, last, took);
    check("send_accept", took, 1);
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 60 && (exp_q.size() != 0 || out_valid); i++) idle(1);
    check("drain_empty", exp_q.size(), 0);
  endtask

  task automatic do_reset();
    #2 rst_n = 1'b0;
    in_valid = 1'b0; in_last = 1'b0;
    exp_q.delete();
    m_idx = 0;
    @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_vec", dut_vec(), '0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Monitor samples just before each rising edge: outputs must match the oldest expected vector.
  initial begin
    forever begin
      @(negedge clk);
      #4;
      if (rst_n && out_valid) begin
        if (exp_q.size() == 0) begin
          check("spurious_out_valid", out_valid, 0);
        end else begin
          check("out_vec", dut_vec(), exp_q[0]);
          if (out_ready) begin
            out_log.push_back(cyc);
            void'(exp_q.pop_front());
          end
        end
      end
      if (rst_n && in_valid && in_ready) in_log.push_back(cyc);
    end
  end

  initial begin
    bit took;
    int acc, c0;

    set_tv(0, 4, 0, mk(1, 2, 3, 4),        mk(5, 6, 7, 8),         mk(1, 2, 3, 4),        mk(5, 6, 7, 8),         4);
    set_tv(1, 4, 0, mk(-128, 127, -1, 0),  mk(127, -128, -1, 1),   mk(-128, 127, -1, 0),  mk(127, -128, -1, 1),   4);
    set_tv(2, 2, 1, mk(9, -3, 0, 0),       mk(2, 2, 0, 0),         mk(9, -3, 0, 0),       mk(2, 2, 0, 0),         2);
    set_tv(3, 1, 1, mk(7, 0, 0, 0),        mk(-7, 0, 0, 0),        mk(7, 0, 0, 0),        mk(-7, 0, 0, 0),        1);
    set_tv(4, 3, 1, mk(10, 20, 30, 99),    mk(-1, -2, -3, 55),     mk(10, 20, 30, 0),     mk(-1, -2, -3, 0),      3);
    set_tv(5, 4, 1, mk(4, 3, 2, 1),        mk(1, 1, 1, 1),         mk(4, 3, 2, 1),        mk(1, 1, 1, 1),         4);

    @(negedge clk);
    do_reset();
    idle(1);

    for (int t = 0; t < 6; t++) begin
      for (int j = 0; j < int'(tv[t].n); j++) begin
        if (j == int'(tv[t].n) - 1) check($sformatf("tv%0d_valid_before", t), out_valid, 0);
        send(elem_t'(tv[t].ix[j]), elem_t'(tv[t].iw[j]), tv[t].last && (j == int'(tv[t].n) - 1));
      end
      check($sformatf("tv%0d_latency", t), out_valid, 1);
      check($sformatf("tv%0d_vec", t), dut_vec(), tv[t].e);
      check($sformatf("tv%0d_dot", t), dot(dut_vec()), dot(tv[t].e));
      idle(2);
    end

    // Reset in the middle of a vector discards the partial data.
    send(11, 13, 0);
    send(12, 14, 0);
    idle(1);
    do_reset();
    out_log.delete();
    for (int j = 0; j < N; j++) send(elem_t'(j + 1), elem_t'(j + 5), 0);
    check("rst_after_vec", dut_vec(), {mk(1, 2, 3, 4), mk(5, 6, 7, 8), 3'd4});
    idle(1);
    wait_drain();
    check("rst_one_output", out_log.size(), 1);

    // Backpressure: offer continuously while the consumer stalls.
    out_ready = 1'b0;
    out_log.delete();
    acc = 0;
    for (int c = 0; c < 10; c++) begin
      step(1'b1, elem_t'(acc + 20), elem_t'(-acc), 1'b0, took);
      if (took) acc++;
    end
    check("bp_accepted", acc, BP_ACC);
    check("bp_in_ready", in_ready, 0);
    check("bp_no_output", out_log.size(), 0);
    out_ready = 1'b1;
    idle(1);
    wait_drain();
    check("bp_drained", out_log.size(), BP_ACC / N);

    // Streaming: three full vectors back to back.
    in_log.delete();
    out_log.delete();
    for (int j = 0; j < 3 * N; j++) send(elem_t'(j * 3 - 17), elem_t'(60 - j), 0);
    idle(1);
    wait_drain();
    check("stream_in_beats", in_log.size(), 3 * N);
    check("stream_out_beats", out_log.size(), 3);
    c0 = (in_log.size() > 0) ? in_log[0] : 0;
    for (int i = 1; i < in_log.size() && i < 3 * N; i++)
      check($sformatf("stream_in_cyc%0d", i), in_log[i] - c0, i + (i / N) * (SPV - N));
    for (int k = 0; k < out_log.size() && k < 3; k++)
      check($sformatf("stream_out_cyc%0d", k), out_log[k] - c0, SPV * k + N);

    // Completion of one bank in the same cycle as the other bank drains.
    in_log.delete();
    out_log.delete();
`ifdef VECTOR_LOADER_DOUBLE_BUFFER_EN
    out_ready = 1'b0;
`endif
    for (int j = 0; j < 7; j++) send(elem_t'(j + 40), elem_t'(j + 1), 0);
    out_ready = 1'b1;
    send(47, 8, 0);
    for (int j = 0; j < N; j++) send(elem_t'(j + 50), elem_t'(-j), 0);
    idle(1);
    wait_drain();
    check("co_outputs", out_log.size(), 3);
`ifdef VECTOR_LOADER_DOUBLE_BUFFER_EN
    check("co_same_cycle", (out_log.size() > 0) ? out_log[0] : -1, (in_log.size() > 7) ? in_log[7] : -2);
`endif

    idle(2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
